// File: rtl/link_rx_checker.sv
// rtl/link_rx_checker.sv - receive-side checker for the 20-bit link test pattern
//
// Purpose: hunts for the frame marker 0xFFFFF, verifies LOCK_FRAMES whole
// frames of the {4'd0, k[11:0], 4'd0} pattern, then counts word errors and
// good frames while locked. Lock is dropped after LOSS_WORDS consecutive bad
// words.
//
// Ports:
//   iPclk      clock, rising edge
//   iRstN      asynchronous active-low reset
//   iD_Link    received link word, one per cycle
//   iClrCnt    synchronous clear of both counters
//   oLock      high while LOCKED
//   oState     0=HUNT, 1=VERIFY, 2=LOCKED
//   oErrPulse  one-cycle pulse per mismatched word while LOCKED
//   oErrCnt    saturating count of mismatched words while LOCKED
//   oFrameCnt  wrapping count of correct markers while LOCKED
module link_rx_checker #(
  parameter int FRAME_LEN   = 2000,
  parameter int LOCK_FRAMES = 2,
  parameter int LOSS_WORDS  = 8,
  parameter int ERR_W       = 16,
  parameter int FRM_W       = 16
) (
  input  logic             iPclk,
  input  logic             iRstN,
  input  logic [19:0]      iD_Link,
  input  logic             iClrCnt,
  output logic             oLock,
  output logic [1:0]       oState,
  output logic             oErrPulse,
  output logic [ERR_W-1:0] oErrCnt,
  output logic [FRM_W-1:0] oFrameCnt
);

  localparam logic [1:0]  HUNT     = 2'd0;
  localparam logic [1:0]  VERIFY   = 2'd1;
  localparam logic [1:0]  LOCKED   = 2'd2;
  localparam logic [19:0] MARKER   = 20'hFFFFF;
  localparam logic [11:0] LAST_IDX = 12'(FRAME_LEN - 1);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [7:0]  LOSS_N   = 8'(LOSS_WORDS);

  logic [1:0]  rState, stateNxt;
  logic [11:0] rExp, expNxt, expInc;
  logic [3:0]  rGood, goodNxt;
  logic [7:0]  rBad, badNxt;
  logic [19:0] expWord;
  logic        atMarker, match;
  logic        errInc, frmInc;

  assign atMarker = (rExp == 12'd0);
  assign expWord  = atMarker ? MARKER : {4'd0, rExp, 4'd0};
  assign match    = (iD_Link == expWord);
  assign expInc   = (rExp == LAST_IDX) ? 12'd0 : rExp + 12'd1;
  assign oState   = rState;

  // State register
  always_ff @(posedge iPclk or negedge iRstN) begin
    if (!iRstN) rState <= HUNT;
    else        rState <= stateNxt;
  end

  // Next-state logic
  always_comb begin
    stateNxt = rState;
    case (rState)
      HUNT:    if (iD_Link == MARKER) stateNxt = VERIFY;
      VERIFY:  begin
        if (!match)                                     stateNxt = HUNT;
        else if (atMarker && (rGood + 4'd1 == LOCK_N)) stateNxt = LOCKED;
      end
      LOCKED:  if (!match && (rBad + 8'd1 == LOSS_N)) stateNxt = HUNT;
      default: stateNxt = HUNT;
    endcase
  end

  // Datapath / output decode
  always_comb begin
    expNxt  = rExp;
    goodNxt = rGood;
    badNxt  = 8'd0;
    errInc  = 1'b0;
    frmInc  = 1'b0;
    case (rState)
      HUNT: begin
        if (iD_Link == MARKER) begin
          expNxt  = (LAST_IDX == 12'd0) ? 12'd0 : 12'd1;
          goodNxt = 4'd0;
        end
      end
      VERIFY: begin
        expNxt = match ? expInc : 12'd0;
        if (match && atMarker) goodNxt = rGood + 4'd1;
      end
      LOCKED: begin
        // rExp free-runs while locked; a misplaced marker is just an error.
        expNxt = expInc;
        if (match) begin
          frmInc = atMarker;
        end else begin
          errInc = 1'b1;
          badNxt = rBad + 8'd1;
        end
        if (stateNxt == HUNT) begin
          expNxt = 12'd0;
          badNxt = 8'd0;
        end
      end
      default: expNxt = 12'd0;
    endcase
  end

  always_ff @(posedge iPclk or negedge iRstN) begin
    if (!iRstN) begin
      rExp      <= 12'd0;
      rGood     <= 4'd0;
      rBad      <= 8'd0;
      oLock     <= 1'b0;
      oErrPulse <= 1'b0;
      oErrCnt   <= '0;
      oFrameCnt <= '0;
    end else begin
      rExp      <= expNxt;
      rGood     <= goodNxt;
      rBad      <= badNxt;
      oLock     <= (stateNxt == LOCKED);
      oErrPulse <= errInc;
      // Clear has priority over any increment in the same cycle.
      if (iClrCnt)                 oErrCnt <= '0;
      else if (errInc && !(&oErrCnt)) oErrCnt <= oErrCnt + ERR_W'(1);
      if (iClrCnt)     oFrameCnt <= '0;
      else if (frmInc) oFrameCnt <= oFrameCnt + FRM_W'(1);
    end
  end

endmodule

// File: doc/link_rx_checker.md
Name: link_rx_checker

Overview:
Receive-side checker for the 20-bit link test pattern produced by the link transmitter.
- Each frame is FRAME_LEN words: marker 0xFFFFF, then words k = 1..FRAME_LEN-1 encoded as {4'd0, k[11:0], 4'd0}.
- The block hunts for the marker and verifies whole frames before declaring lock.
- Once locked, it counts word errors and complete frames, and drops lock on sustained corruption.
- Sits after the deserializer/PCS word output, in the iPclk domain. Feeds status registers and link-up logic.

Parameters:
FRAME_LEN, 2000, words per frame including the marker (2..4096).
LOCK_FRAMES, 2, consecutive error-free complete frames required in VERIFY before LOCKED (1..15).
LOSS_WORDS, 8, consecutive mismatched words in LOCKED that force return to HUNT (1..255).
ERR_W, 16, width of the error counter (saturating).
FRM_W, 16, width of the frame counter (wrapping).

Ports:
iPclk  input  1  clock; all logic rising-edge.
iRstN  input  1  asynchronous active-low reset.
iD_Link  input  20  received link word, one per cycle, always valid.
iClrCnt  input  1  synchronous clear of oErrCnt and oFrameCnt.
oLock  output  1  high while state is LOCKED.
oState  output  2  0=HUNT, 1=VERIFY, 2=LOCKED.
oErrPulse  output  1  one-cycle pulse per mismatched word while LOCKED.
oErrCnt  output  ERR_W  mismatched words counted while LOCKED; saturates at all-ones.
oFrameCnt  output  FRM_W  correctly received markers while LOCKED; wraps.

Behaviour:
- Reset (iRstN low, asynchronous): state HUNT, expected index rExp=0, good-frame count=0, bad-run count=0. All outputs 0.
- Timing: iD_Link is sampled at each edge and compared against the expected word for rExp. All outputs are registered and reflect the sampled word one cycle later.
- Expected word: 0xFFFFF when rExp==0, otherwise {4'd0, rExp[11:0], 4'd0}.
- rExp advances by 1 each cycle in VERIFY and LOCKED. It wraps from FRAME_LEN-1 to 0.
- HUNT:
  - Word == 0xFFFFF: go to VERIFY, rExp<=1, good-frame count<=0.
  - Any other word: ignored.
- VERIFY:
  - Any mismatch: go to HUNT. No error counted, no pulse.
  - Match at rExp==0: good-frame count +1. If it reaches LOCK_FRAMES, go to LOCKED.
  - Example with LOCK_FRAMES=2: initial marker, then 2 more correct markers, then lock.
- LOCKED:
  - Match: bad-run count<=0. If rExp==0, oFrameCnt +1.
  - Mismatch (including a missing marker or a marker at the wrong position): oErrPulse=1, oErrCnt +1 (saturating), bad-run count +1.
  - When bad-run count reaches LOSS_WORDS: go to HUNT, oLock<=0, and the error on that word is still counted.
  - rExp never realigns while LOCKED; it free-runs.
- Leaving LOCKED via LOSS_WORDS: the state is HUNT on the next cycle. The following word is examined in HUNT; a marker there goes straight to VERIFY.
- iClrCnt:
  - Both counters are 0 on the next cycle. Clear wins over a simultaneous increment.
  - oErrPulse still asserts for a simultaneous mismatch.
  - State and lock are unaffected.
- oErrCnt at all-ones stays there until iClrCnt or reset. oFrameCnt wraps to 0.
- Reset mid-operation returns immediately to the reset values. Nothing is retained.

Test Plan:
- Clean transmitter stream from reset (marker at word index 1, 2001, 4001) -> oState=1 from the cycle after index 1; oLock rises the cycle after index 4001 is sampled; oErrCnt=0; oFrameCnt=0; oFrameCnt=1 after index 6001.
- Locked, flip bit 4 of one word (0x00050 -> 0x00040) -> oErrPulse high exactly one cycle; oErrCnt=1; oLock stays 1; next marker increments oFrameCnt.
- Locked, 8 consecutive words forced to 0x00000 -> oErrCnt=8; oLock falls the cycle after the 8th; oState=0. With a clean stream afterwards, relock occurs after 3 markers.
- Locked, 7 bad words, 1 good, 7 bad -> oErrCnt=14; lock retained.
- In VERIFY, corrupt word index 500 -> oState returns to 0; oErrCnt stays 0; oErrPulse never asserted.
- ERR_W=4, locked, 20 single-word errors spaced apart -> oErrCnt saturates at 15. iClrCnt asserted with a simultaneous error -> oErrCnt=0, pulse still seen.
- Assert iRstN low while locked, mid-frame -> all outputs 0 immediately. After release, lock requires the full hunt/verify sequence again.
